// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HIGH
    } rx_state_t;

    localparam int unsigned MIN_CLKS_PER_BIT = 4;

    // Raw encoding 3 is an alias for "no parity".
    function automatic parity_t decode_parity(input logic [1:0] raw);
        case (raw)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial line, runtime configuration and received-frame status of the UART receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
);
    logic                 rx_serial;
    logic [CNT_W-1:0]     cfg_clks_per_bit;
    logic [1:0]           cfg_parity;
    logic                 cfg_stop2;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_busy;

    modport master (
        output rx_serial, cfg_clks_per_bit, cfg_parity, cfg_stop2,
        input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_busy
    );

    modport slave (
        input  rx_serial, cfg_clks_per_bit, cfg_parity, cfg_stop2,
        output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser plus bit-value strobe; UART_RX_MAJORITY_EN selects a
// 2-of-3 vote over cnt = mid-1, mid, mid+1 instead of a single sample at mid.
module uart_rx_sampler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_serial,
    input  logic             active,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] mid,
    output logic             line,
    output logic             bit_strobe,
    output logic             bit_val
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    logic s0_q, s1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else if (active) begin
            if (cnt == mid - CNT_W'(1)) s0_q <= sync2_q;
            if (cnt == mid) s1_q <= sync2_q;
        end
    end

    // Third vote is the live sample at mid+1, where the decision is taken.
    assign bit_strobe = active && (cnt == mid + CNT_W'(1));
    assign bit_val    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
`else
    assign bit_strobe = active && (cnt == mid);
    assign bit_val    = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (divisor, parity, stop bits) with error and
// break flags. Optional majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS        = 8,
    parameter int CNT_W            = 16,
    parameter int DEF_CLKS_PER_BIT = 868
) (
    input logic          clk,
    input logic          rst,
    uart_rx_cfg_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, div_q, mid, cfg_div;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    parity_t              par_q;
    logic                 stop2_q;
    logic [DATA_BITS-1:0] data_sr_q, data_out_q;
    logic                 par_bit_q, frame_err_q, stop0_low_q;
    logic                 perr_q, ferr_q, brk_q;
    logic                 line, bit_strobe, bit_val, bit_end, active;
    logic                 par_xor, perr_calc, brk_calc;

    assign cfg_div = (bus.cfg_clks_per_bit < CNT_W'(MIN_CLKS_PER_BIT)) ?
                     CNT_W'(MIN_CLKS_PER_BIT) : bus.cfg_clks_per_bit;
    assign mid     = div_q >> 1;
    assign bit_end = (cnt_q == div_q - CNT_W'(1));
    assign active  = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

    uart_rx_sampler #(
        .CNT_W(CNT_W)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (bus.rx_serial),
        .active     (active),
        .cnt        (cnt_q),
        .mid        (mid),
        .line       (line),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!line) state_d = START;
            START: begin
                if (bit_strobe && bit_val) state_d = IDLE;
                else if (bit_end)          state_d = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx_q == LAST_IDX)
                    state_d = (par_q == PAR_NONE) ? STOP : PARITY;
            end
            PARITY:    if (bit_end) state_d = STOP;
            // Leave on the last stop sample so a back-to-back start edge is not missed.
            STOP:      if (bit_strobe && stop_idx_q == stop2_q) state_d = DONE;
            DONE:      state_d = frame_err_q ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (line) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign par_xor   = (^data_sr_q) ^ par_bit_q;
    assign perr_calc = ((par_q == PAR_EVEN) && par_xor) || ((par_q == PAR_ODD) && !par_xor);
    assign brk_calc  = (data_sr_q == '0) && ((par_q == PAR_NONE) || !par_bit_q) && stop0_low_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            div_q       <= CNT_W'(DEF_CLKS_PER_BIT);
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            data_sr_q   <= '0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop0_low_q <= 1'b0;
            data_out_q  <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            if (!active || bit_end) cnt_q <= '0;
            else                    cnt_q <= cnt_q + CNT_W'(1);

            unique case (state_q)
                IDLE: begin
                    if (!line) begin
                        div_q       <= cfg_div;
                        par_q       <= decode_parity(bus.cfg_parity);
                        stop2_q     <= bus.cfg_stop2;
                        bit_idx_q   <= '0;
                        stop_idx_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                        stop0_low_q <= 1'b0;
                    end
                end
                DATA: begin
                    // Shift in from the top so the first (LSB) bit lands in bit 0.
                    if (bit_strobe) data_sr_q <= {bit_val, data_sr_q[DATA_BITS-1:1]};
                    if (bit_end && bit_idx_q != LAST_IDX) bit_idx_q <= bit_idx_q + 4'd1;
                end
                PARITY: if (bit_strobe) par_bit_q <= bit_val;
                STOP: begin
                    if (bit_strobe) begin
                        if (!bit_val) frame_err_q <= 1'b1;
                        if (!stop_idx_q) stop0_low_q <= !bit_val;
                    end
                    if (bit_end) stop_idx_q <= 1'b1;
                end
                DONE: begin
                    data_out_q <= data_sr_q;
                    perr_q     <= perr_calc;
                    ferr_q     <= frame_err_q;
                    brk_q      <= brk_calc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rx_valid      = (state_q == DONE);
        bus.rx_busy       = (state_q != IDLE);
        bus.rx_data       = data_out_q;
        bus.rx_parity_err = perr_q;
        bus.rx_frame_err  = ferr_q;
        bus.rx_break      = brk_q;
        if (state_q == DONE) begin
            bus.rx_data       = data_sr_q;
            bus.rx_parity_err = perr_calc;
            bus.rx_frame_err  = frame_err_q;
            bus.rx_break      = brk_calc;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8-bit and a 5-bit receiver driven with hand-built frames.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8), .CNT_W(16)) bus8 ();
    uart_rx_cfg_if #(.DATA_BITS(5), .CNT_W(16)) bus5 ();

    uart_rx_cfg #(.DATA_BITS(8), .CNT_W(16), .DEF_CLKS_PER_BIT(868)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    uart_rx_cfg #(.DATA_BITS(5), .CNT_W(16), .DEF_CLKS_PER_BIT(868)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    int checks = 0;
    int errors = 0;

    int         v8_cnt = 0;
    logic [7:0] v8_data = '0;
    logic       v8_perr = 1'b0, v8_ferr = 1'b0, v8_brk = 1'b0;
    int         v5_cnt = 0;
    logic [4:0] v5_data = '0, v5_prev = '0;

    always @(negedge clk) begin
        if (bus8.rx_valid === 1'b1) begin
            v8_cnt  <= v8_cnt + 1;
            v8_data <= bus8.rx_data;
            v8_perr <= bus8.rx_parity_err;
            v8_ferr <= bus8.rx_frame_err;
            v8_brk  <= bus8.rx_break;
        end
        if (bus5.rx_valid === 1'b1) begin
            v5_cnt  <= v5_cnt + 1;
            v5_prev <= v5_data;
            v5_data <= bus5.rx_data;
        end
    end

    task automatic drive_level(input int sel, input logic lvl, input int cycles);
        if (sel == 8) bus8.rx_serial = lvl;
        else          bus5.rx_serial = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bits(input int sel, input logic [31:0] vec, input int n, input int div);
        for (int i = 0; i < n; i++) drive_level(sel, vec[i], div);
    endtask

    task automatic test_reset;
        bus8.rx_serial = 1'b1; bus8.cfg_clks_per_bit = 16'd16;
        bus8.cfg_parity = 2'd0; bus8.cfg_stop2 = 1'b0;
        bus5.rx_serial = 1'b1; bus5.cfg_clks_per_bit = 16'd8;
        bus5.cfg_parity = 2'd0; bus5.cfg_stop2 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus8.rx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b, expected 0", bus8.rx_valid); end
        checks++; if (bus8.rx_data !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h, expected 00", bus8.rx_data); end
        checks++; if ({bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_break} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b%b%b, expected 000",
                bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_break); end
        checks++; if (bus8.rx_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b, expected 0", bus8.rx_busy); end
        checks++; if (bus5.rx_data !== 5'h00) begin errors++;
            $display("FAIL reset_data5: got %h, expected 00", bus5.rx_data); end
    endtask

    task automatic test_8n1;
        int c0;
        c0 = v8_cnt;
        send_bits(8, {22'h0, 1'b1, 8'hA5, 1'b0}, 10, 16);
        drive_level(8, 1'b1, 48);
        checks++; if (v8_cnt - c0 !== 1) begin errors++;
            $display("FAIL 8n1_pulses: got %0d, expected 1", v8_cnt - c0); end
        checks++; if (v8_data !== 8'hA5) begin errors++;
            $display("FAIL 8n1_data: got %h, expected a5", v8_data); end
        checks++; if ({v8_perr, v8_ferr, v8_brk} !== 3'b000) begin errors++;
            $display("FAIL 8n1_flags: got %b%b%b, expected 000", v8_perr, v8_ferr, v8_brk); end
        checks++; if (bus8.rx_busy !== 1'b0) begin errors++;
            $display("FAIL 8n1_busy: got %b, expected 0", bus8.rx_busy); end
        checks++; if (bus8.rx_data !== 8'hA5) begin errors++;
            $display("FAIL 8n1_hold: got %h, expected a5", bus8.rx_data); end
    endtask

    task automatic test_false_start;
        int c0;
        c0 = v8_cnt;
        drive_level(8, 1'b0, 3);
        drive_level(8, 1'b1, 2);
        checks++; if (bus8.rx_busy !== 1'b1) begin errors++;
            $display("FAIL fstart_busy_hi: got %b, expected 1", bus8.rx_busy); end
        drive_level(8, 1'b1, 9);
        checks++; if (bus8.rx_busy !== 1'b0) begin errors++;
            $display("FAIL fstart_busy_lo: got %b, expected 0", bus8.rx_busy); end
        drive_level(8, 1'b1, 32);
        checks++; if (v8_cnt - c0 !== 0) begin errors++;
            $display("FAIL fstart_pulses: got %0d, expected 0", v8_cnt - c0); end
        checks++; if ({bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_break} !== 3'b000) begin
            errors++; $display("FAIL fstart_flags: got %b%b%b, expected 000",
                bus8.rx_parity_err, bus8.rx_frame_err, bus8.rx_break); end
    endtask

    task automatic test_parity_even;
        int c0;
        bus8.cfg_parity = 2'd1;
        c0 = v8_cnt;
        send_bits(8, {21'h0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16);
        drive_level(8, 1'b1, 32);
        checks++; if (v8_cnt - c0 !== 1) begin errors++;
            $display("FAIL even_bad_pulses: got %0d, expected 1", v8_cnt - c0); end
        checks++; if (v8_data !== 8'h3C) begin errors++;
            $display("FAIL even_bad_data: got %h, expected 3c", v8_data); end
        checks++; if ({v8_perr, v8_ferr} !== 2'b10) begin errors++;
            $display("FAIL even_bad_flags: got perr=%b ferr=%b, expected 1 0", v8_perr, v8_ferr); end
        send_bits(8, {21'h0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16);
        drive_level(8, 1'b1, 32);
        checks++; if (v8_cnt - c0 !== 2) begin errors++;
            $display("FAIL even_ok_pulses: got %0d, expected 2", v8_cnt - c0); end
        checks++; if ({v8_perr, v8_ferr} !== 2'b00) begin errors++;
            $display("FAIL even_ok_flags: got perr=%b ferr=%b, expected 0 0", v8_perr, v8_ferr); end
    endtask

    task automatic test_stop2_frame_err;
        int c0;
        bus8.cfg_parity = 2'd2;
        bus8.cfg_stop2  = 1'b1;
        c0 = v8_cnt;
        // Odd parity over 0x81 (two ones) needs parity bit 1; second stop bit held low.
        send_bits(8, {20'h0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 12, 16);
        drive_level(8, 1'b0, 32);
        checks++; if (v8_cnt - c0 !== 1) begin errors++;
            $display("FAIL stop2_pulses: got %0d, expected 1", v8_cnt - c0); end
        checks++; if (v8_data !== 8'h81) begin errors++;
            $display("FAIL stop2_data: got %h, expected 81", v8_data); end
        checks++; if ({v8_perr, v8_ferr, v8_brk} !== 3'b010) begin errors++;
            $display("FAIL stop2_flags: got %b%b%b, expected 010", v8_perr, v8_ferr, v8_brk); end
        checks++; if (bus8.rx_busy !== 1'b1) begin errors++;
            $display("FAIL stop2_wait_high: got busy=%b, expected 1", bus8.rx_busy); end
        drive_level(8, 1'b1, 6);
        checks++; if (bus8.rx_busy !== 1'b0) begin errors++;
            $display("FAIL stop2_release: got busy=%b, expected 0", bus8.rx_busy); end
        drive_level(8, 1'b1, 32);
    endtask

    task automatic test_break;
        int c0;
        bus8.cfg_parity = 2'd0;
        bus8.cfg_stop2  = 1'b0;
        c0 = v8_cnt;
        drive_level(8, 1'b0, 40 * 16);
        checks++; if (v8_cnt - c0 !== 1) begin errors++;
            $display("FAIL break_pulses: got %0d, expected 1", v8_cnt - c0); end
        checks++; if ({v8_brk, v8_ferr, v8_perr} !== 3'b110) begin errors++;
            $display("FAIL break_flags: got brk=%b ferr=%b perr=%b, expected 1 1 0",
                v8_brk, v8_ferr, v8_perr); end
        checks++; if (v8_data !== 8'h00) begin errors++;
            $display("FAIL break_data: got %h, expected 00", v8_data); end
        drive_level(8, 1'b1, 48);
        checks++; if (v8_cnt - c0 !== 1 || bus8.rx_busy !== 1'b0) begin errors++;
            $display("FAIL break_idle: got pulses=%0d busy=%b, expected 1 0",
                v8_cnt - c0, bus8.rx_busy); end
        send_bits(8, {22'h0, 1'b1, 8'h5A, 1'b0}, 10, 16);
        drive_level(8, 1'b1, 48);
        checks++; if (v8_cnt - c0 !== 2 || v8_data !== 8'h5A) begin errors++;
            $display("FAIL break_next: got pulses=%0d data=%h, expected 2 5a", v8_cnt - c0, v8_data); end
        checks++; if ({v8_brk, v8_ferr} !== 2'b00) begin errors++;
            $display("FAIL break_next_flags: got brk=%b ferr=%b, expected 0 0", v8_brk, v8_ferr); end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = v5_cnt;
        send_bits(5, {18'h0, 1'b1, 5'h0A, 1'b0, 1'b1, 5'h15, 1'b0}, 14, 8);
        drive_level(5, 1'b1, 24);
        checks++; if (v5_cnt - c0 !== 2) begin errors++;
            $display("FAIL b2b_pulses: got %0d, expected 2", v5_cnt - c0); end
        checks++; if (v5_prev !== 5'h15) begin errors++;
            $display("FAIL b2b_first: got %h, expected 15", v5_prev); end
        checks++; if (v5_data !== 5'h0A) begin errors++;
            $display("FAIL b2b_second: got %h, expected 0a", v5_data); end
        checks++; if ({bus5.rx_parity_err, bus5.rx_frame_err, bus5.rx_break} !== 3'b000) begin
            errors++; $display("FAIL b2b_flags: got %b%b%b, expected 000",
                bus5.rx_parity_err, bus5.rx_frame_err, bus5.rx_break); end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        c0 = v5_cnt;
        // Full 0x15 frame, then start bit and two data bits of 0x0A.
        send_bits(5, {22'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h15, 1'b0}, 10, 8);
        rst = 1'b1;
        bus5.rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus5.rx_data !== 5'h00 || bus5.rx_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_outputs: got data=%h valid=%b, expected 00 0",
                bus5.rx_data, bus5.rx_valid); end
        checks++; if (bus5.rx_busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_busy: got %b, expected 0", bus5.rx_busy); end
        rst = 1'b0;
        drive_level(5, 1'b1, 40);
        checks++; if (v5_cnt - c0 !== 1) begin errors++;
            $display("FAIL rstmid_pulses: got %0d, expected 1", v5_cnt - c0); end
        checks++; if (bus5.rx_data !== 5'h00) begin errors++;
            $display("FAIL rstmid_hold: got %h, expected 00", bus5.rx_data); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_8n1;
        test_false_start;
        test_parity_even;
        test_stop2_frame_err;
        test_break;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
